// File: rtl/window_buffer.sv
// window_buffer
//   Sliding-window sample buffer for one channel's feature extractor.
//   Keeps the last WINDOW_SIZE signed samples and, every WINDOW_STEP new
//   samples after the first full window, publishes a held snapshot with a
//   one-cycle start pulse. Windows completing while the extractor is still
//   busy are dropped and counted.
//
// Ports
//   clk          : single clock, rising edge
//   nrst         : asynchronous active-low reset
//   sample_valid : sample_in accepted on this edge
//   sample_in    : signed two's-complement sample
//   feat_done    : one-cycle pulse, extractor consumed the current snapshot
//   samples      : held snapshot, index 0 oldest, WINDOW_SIZE-1 newest
//   en           : one-cycle pulse, new snapshot valid
//   busy         : snapshot owned by extractor
//   overrun      : one-cycle pulse, a completed window was dropped
//   overrun_cnt  : saturating count of dropped windows
module window_buffer #(
  parameter int unsigned WINDOW_SIZE = 256,
  parameter int unsigned WINDOW_STEP = 128,
  parameter int unsigned SAMPLE_SIZE = 16
) (
  input  logic                                    clk,
  input  logic                                    nrst,
  input  logic                                    sample_valid,
  input  logic [SAMPLE_SIZE-1:0]                  sample_in,
  input  logic                                    feat_done,
  output logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] samples,
  output logic                                    en,
  output logic                                    busy,
  output logic                                    overrun,
  output logic [7:0]                              overrun_cnt
);

  localparam int unsigned CW = $clog2(WINDOW_SIZE) + 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(WINDOW_SIZE - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(WINDOW_STEP - 1);

  typedef enum logic {FILL, STEP} state_t;

  state_t state, state_d;
  logic [CW-1:0] fill_cnt, fill_cnt_d;
  logic [CW-1:0] step_cnt, step_cnt_d;
  logic complete;
  logic take, drop, busy_d;

  logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] sr, sr_shifted;

  // Newest sample enters at the top, everything else moves one toward index 0.
  assign sr_shifted = {sample_in, sr[WINDOW_SIZE-1:1]};

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= FILL;
      fill_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_d;
      fill_cnt <= fill_cnt_d;
      step_cnt <= step_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state;
    fill_cnt_d = fill_cnt;
    step_cnt_d = step_cnt;
    complete   = 1'b0;
    if (sample_valid) begin
      if (state == FILL) begin
        fill_cnt_d = fill_cnt + CW'(1);
        if (fill_cnt == FILL_LAST) begin
          complete   = 1'b1;
          state_d    = STEP;
          step_cnt_d = '0;
        end
      end else begin
        if (step_cnt == STEP_LAST) begin
          complete   = 1'b1;
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt + CW'(1);
        end
      end
    end
  end

  // Output decisions: a completing window is published if the snapshot is
  // free or being released this very cycle, otherwise it is dropped.
  always_comb begin
    take   = complete && (!busy || feat_done);
    drop   = complete && !take;
    busy_d = busy;
    if (take)
      busy_d = 1'b1;
    else if (feat_done)
      busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr          <= '0;
      samples     <= '0;
      en          <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (sample_valid)
        sr <= sr_shifted;
      if (take)
        samples <= sr_shifted;
      en      <= take;
      overrun <= drop;
      busy    <= busy_d;
      if (drop && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: doc/window_buffer.md
# window_buffer

Sliding-window sample buffer feeding one channel's feature extractor (the mean-amplitude extractor and siblings sharing its `en`/`samples`/`done` interface). It accepts a stream of signed EEG samples, keeps the last `WINDOW_SIZE` of them, and every `WINDOW_STEP` new samples (after the first full window) publishes a stable snapshot of the window with a one-cycle start pulse. The snapshot is held unchanged until the downstream extractor reports `done`; windows that complete while it is still busy are dropped and counted.

## Interface

- `WINDOW_SIZE`, 256: samples per window; power of two, ≥ 4.
- `WINDOW_STEP`, 128: new samples between consecutive windows; 1 ≤ STEP ≤ WINDOW_SIZE.
- `SAMPLE_SIZE`, 16: bits per signed sample.
- `clk`  in  1  single clock; all state updates on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  `sample_in` is accepted on this edge.
- `sample_in`  in  SAMPLE_SIZE  signed sample, two's complement.
- `feat_done`  in  1  one-cycle pulse from the extractor: current snapshot consumed.
- `samples`  out  [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0]  held window snapshot; index 0 oldest, WINDOW_SIZE-1 newest.
- `en`  out  1  one-cycle pulse: new snapshot valid, start extraction.
- `busy`  out  1  snapshot owned by extractor (en issued, feat_done not yet seen).
- `overrun`  out  1  one-cycle pulse: a completed window was dropped.
- `overrun_cnt`  out  8  saturating count of dropped windows.

## Operation

- Internal shift register `sr[WINDOW_SIZE]`; on accepted sample: `sr[i] <= sr[i+1]`, `sr[WINDOW_SIZE-1] <= sample_in`. Not shifted when `sample_valid` low.
- State machine, two states:
  - FILL: `fill_cnt` ($clog2(WINDOW_SIZE)+1 bits) counts accepted samples. When the accepted sample is the WINDOW_SIZE-th, window completes; go to STEP, clear `step_cnt`.
  - STEP: `step_cnt` counts accepted samples; when the accepted sample makes it equal WINDOW_STEP, window completes and `step_cnt` returns to 0.
- Window completion (on the accepting edge):
  - If `busy` is low, or `feat_done` is high this cycle: `samples` <= shifted contents including the new sample; `en` <= 1; `busy` <= 1.
  - Else: `samples` unchanged; `overrun` <= 1; `overrun_cnt` <= min(cnt+1, 255). Step counting continues normally (next window still STEP samples later).
- `feat_done` with no completion: `busy` <= 0. `feat_done` while `busy` low: ignored.
- `samples` changes only on an accepted completion; never during `busy`.
- `en`, `overrun` are high for exactly one cycle.
- Samples are stored bit-exact; no arithmetic on sample values.

## Timing

- Reset (nrst low, async): `samples` all 0, `en` 0, `busy` 0, `overrun` 0, `overrun_cnt` 0, `sr` all 0, `fill_cnt` 0, `step_cnt` 0, state FILL. Reset mid-window discards all partial data; next window requires WINDOW_SIZE fresh samples.
- Latency: `samples` and `en` valid the cycle after the edge accepting the completing sample; `busy` rises same edge as `en`.
- `busy` falls on the edge sampling `feat_done` high (unless re-set by a simultaneous completion, in which case it stays high and `en` pulses).
- Extractor in the same clock domain returns to idle when `done` pulses, so an `en` one cycle later is accepted.
- Back-to-back valid samples sustained at one per cycle; no backpressure on the input side.
- WINDOW_STEP = WINDOW_SIZE: non-overlapping windows; WINDOW_STEP = 1: a window completes on every sample after fill.

## Test plan

- Params W=8, STEP=4. Reset, feed samples 1..8 one per cycle -> single `en` after sample 8, `samples` = {8,7,...,1} (index 0 = 1), `busy` = 1; no `en` earlier.
- Continue 9..12, pulse `feat_done` after sample 10 -> `en` after sample 12 with `samples` index0..7 = 5..12; `busy` 0 between done and en.
- Withhold `feat_done`, feed 9..16 -> no `en` after 12 or 16; `overrun` pulses twice, `overrun_cnt` = 2, `samples` still 1..8.
- `feat_done` on the same cycle sample 12 is accepted -> `en` next cycle, `samples` = 5..12, `busy` stays 1, no overrun.
- Gaps: toggle `sample_valid` every other cycle with values -1,-2,...,-8 -> window 0x FFFF..FFF8 ordering preserved, completion only on 8th valid sample.
- Assert nrst mid-fill after 5 samples -> all outputs 0; subsequent 8 samples 100..107 produce `en` with `samples` = 100..107.
